// File: rtl/data_mem_resp.sv
// ---------------------------------------------------------------------------
// data_mem_resp
//   Single-port data memory with a valid/ready request channel and a
//   valid/ready response channel. Accesses are fully serialized by a
//   three-state FSM (IDLE -> WAIT -> RESP). Each access takes a fixed number
//   of wait states. Byte and halfword stores use byte enables. Loads are
//   sign- or zero-extended following RV32I funct3 encoding.
//
//   Optional feature: define DATA_MEM_RESP_ERR_EN to report misaligned and
//   out-of-range accesses through resp_err. When it is undefined, low address
//   bits are aligned down and high address bits wrap modulo 4*DEPTH.
//   Unsupported sizes always fault, whatever the configuration.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, at most 2**29)
//   WAIT_CYCLES  wait states per access, 0..15
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous reset, active low
//   req_valid    request present          req_ready   request accepted (IDLE)
//   req_we       1 = store, 0 = load      req_addr    byte address
//   req_size     RV32I funct3             req_wdata   store data (low bytes)
//   resp_valid   response present         resp_ready  response consumed
//   resp_rdata   extended load data (0 for stores and faults)
//   resp_err     access faulted
// ---------------------------------------------------------------------------
module data_mem_resp #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        enter_resp;

    logic        we_p0;
    logic [31:0] addr_p0;
    logic [2:0]  size_p0;
    logic [31:0] wdata_p0;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [2:0]  acc_size;
    logic [31:0] acc_wdata;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          size_ok;
    logic          misalign;
    logic          oob;
    logic          fault;
    logic [31:0]   word_rd;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    logic [31:0] mem [DEPTH];

    // Pick the addressed byte/half and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  size,
                                             input logic [1:0]  sel);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = sel[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  load_ext = 32'(b);
            3'b001:  load_ext = 32'(h);
            3'b010:  load_ext = word;
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] sel);
        case (sz)
            2'b00:   store_be = 4'b0001 << sel;
            2'b01:   store_be = sel[1] ? 4'b1100 : 4'b0011;
            2'b10:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Replicate the low-order store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    // With zero wait states the access completes on the accept edge itself,
    // so the live request is used in IDLE and the captured copy otherwise.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : we_p0;
        acc_addr  = (state == IDLE) ? req_addr  : addr_p0;
        acc_size  = (state == IDLE) ? req_size  : size_p0;
        acc_wdata = (state == IDLE) ? req_wdata : wdata_p0;
    end

    always_comb begin
        idx      = acc_addr[AW+1:2];
        lane     = acc_addr[1:0];
        size_ok  = (acc_size == 3'b000) || (acc_size == 3'b001) || (acc_size == 3'b010) ||
                   (acc_size == 3'b100) || (acc_size == 3'b101);
        misalign = ((acc_size[1:0] == 2'b01) && acc_addr[0]) ||
                   ((acc_size[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        oob      = (acc_addr[31:AW+2] != '0);
        word_rd  = mem[idx];
        be       = store_be(acc_size[1:0], lane);
        wlanes   = store_lanes(acc_size[1:0], acc_wdata);
    end

`ifdef DATA_MEM_RESP_ERR_EN
    assign fault = !size_ok || misalign || oob;
`else
    // Alignment and range are ignored: the index slice already wraps and
    // the lane selection already aligns down.
    logic unused_chk;
    assign unused_chk = misalign | oob;
    assign fault      = !size_ok;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                // No accept here: a new request waits for IDLE.
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- control and response registers ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (enter_resp) begin
                resp_err   <= fault;
                resp_rdata <= (fault || acc_we) ? 32'd0 : load_ext(word_rd, acc_size, lane);
            end
        end
    end

    // ---- request capture (data only, not reset) ----
    always_ff @(posedge clk) begin
        if (req_ready && req_valid) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            size_p0  <= req_size;
            wdata_p0 <= req_wdata;
        end
    end

    // ---- storage: commit on the edge entering RESP, dropped under reset ----
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: scoreboard with a byte-addressed reference
// model; a second instance with zero wait states checks back-to-back timing.
module tb_data_mem_resp;

    localparam int DEPTH_M = 256;
    localparam int W_M     = 1;

    logic clk = 0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic [2:0]  req_size0;
    logic        resp_valid0, resp_ready0, resp_err0;
    logic [31:0] resp_rdata0;

    data_mem_resp #(.DEPTH(DEPTH_M), .WAIT_CYCLES(W_M)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_resp #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_size(req_size0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: little-endian byte array, 4*DEPTH bytes.
    logic [7:0] bm [4*DEPTH_M];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int n;
        bit sgn;
        int unsigned a;
        logic [31:0] v;
        rd  = 32'd0;
        err = 1'b0;
        n   = 0;
        sgn = 0;
        case (size)
            3'b000: begin n = 1; sgn = 1; end
            3'b001: begin n = 2; sgn = 1; end
            3'b010: begin n = 4; sgn = 0; end
            3'b100: begin n = 1; sgn = 0; end
            3'b101: begin n = 2; sgn = 0; end
            default: n = 0;
        endcase
        if (n == 0) begin
            err = 1'b1;
            return;
        end
`ifdef DATA_MEM_RESP_ERR_EN
        if ((addr % n) != 0 || addr >= 4 * DEPTH_M) begin
            err = 1'b1;
            return;
        end
`endif
        a = addr % (4 * DEPTH_M);
        a = a - (a % n);
        if (we) begin
            for (int k = 0; k < n; k++) bm[a + k] = wdata[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = bm[a + k];
            if (sgn && v[8*n - 1])
                for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   rr_hold = 0;

    // Response-side backpressure: random, or held low on request.
    initial begin
        resp_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_hold > 0) begin
                resp_ready = 0;
                rr_hold--;
            end else begin
                resp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops one expectation per response, then checks it stays put.
    exp_t cur;
    bit   in_resp  = 0;
    bit   chk_idle = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp  = 0;
            chk_idle = 0;
        end else begin
            if (chk_idle) begin
                chk_idle = 0;
                chk("idle_after_consume", {30'd0, req_ready, resp_valid}, 32'd2);
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        cur     = q.pop_front();
                        in_resp = 1;
                        chk("latency", cyc, cur.cyc);
                        chk("rdata", resp_rdata, cur.rdata);
                        chk("err", {31'd0, resp_err}, {31'd0, cur.err});
                    end
                end else begin
                    chk("hold_rdata", resp_rdata, cur.rdata);
                    chk("hold_err", {31'd0, resp_err}, {31'd0, cur.err});
                    chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
                end
                if (resp_ready && in_resp) begin
                    in_resp  = 0;
                    chk_idle = 1;
                end
            end
        end
    end

    // Issue one request; live=0 means no model update and no expectation.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input bit live, input bit use_k,
                         input logic [31:0] k_rd, input logic k_err, input int hold);
        int   n;
        exp_t e;
        logic [31:0] m_rd;
        logic m_err;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("issue_timeout", 32'd1, 32'd0);
            return;
        end
        if (live) begin
            model(we, addr, size, wdata, m_rd, m_err);
            e.rdata = use_k ? k_rd : m_rd;
            e.err   = use_k ? k_err : m_err;
            e.cyc   = cyc + 1 + W_M;
            q.push_back(e);
        end
        if (hold > 0) rr_hold = hold;
        req_valid = 1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_size  = 3'($urandom_range(0, 7));
        req_wdata = $urandom;
    endtask

    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] bad   [3] = '{3'b011, 3'b110, 3'b111};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } op0_t;

    op0_t ops0 [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_size0 = 0; req_wdata0 = 0;
        resp_ready0 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_w0_req_ready", {31'd0, req_ready0}, 32'd1);

        // Give the exercised words known contents.
        for (int i = 0; i < 16; i++) issue(1, 32'(i * 4), 3'b010, $urandom, 1, 0, 0, 0, 0);

        // Directed store/load sequence.
        issue(1, 32'h10, 3'b010, 32'hDEADBEEF, 1, 1, 32'h0, 0, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 1, 1, 32'hDEADBEEF, 0, 0);
        issue(1, 32'h11, 3'b000, 32'h000000AA, 1, 1, 32'h0, 0, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 1, 1, 32'hDEADAAEF, 0, 8);
        issue(0, 32'h11, 3'b000, 32'h0, 1, 1, 32'hFFFFFFAA, 0, 0);
        issue(0, 32'h11, 3'b100, 32'h0, 1, 1, 32'h000000AA, 0, 0);
`ifdef DATA_MEM_RESP_ERR_EN
        issue(0, 32'h12, 3'b010, 32'h0, 1, 1, 32'h0, 1, 0);
        issue(1, 32'h13, 3'b001, 32'h5555, 1, 1, 32'h0, 1, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 1, 1, 32'hDEADAAEF, 0, 0);
`else
        issue(0, 32'h12, 3'b010, 32'h0, 1, 1, 32'hDEADAAEF, 0, 0);
        issue(1, 32'h13, 3'b001, 32'h5555, 1, 1, 32'h0, 0, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 1, 1, 32'h5555AAEF, 0, 0);
`endif
        issue(0, 32'h10, 3'b011, 32'h0, 1, 1, 32'h0, 1, 0);
        issue(1, 32'h14, 3'b111, 32'h12345678, 1, 1, 32'h0, 1, 0);

        // Reset while the store sits in WAIT: it must be dropped.
        issue(1, 32'h20, 3'b010, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_err", {31'd0, resp_err}, 32'd0);
        issue(0, 32'h20, 3'b010, 32'h0, 1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [2:0]  s;
            int r;
            a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH_M * $urandom_range(1, 8));
            r = $urandom_range(0, 15);
            s = (r < 13) ? legal[r % 5] : bad[r - 13];
            issue(1'($urandom_range(0, 1)), a, s, $urandom, 1, 0, 0, 0,
                  ($urandom_range(0, 9) == 0) ? 6 : 0);
        end

        for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        // Zero-wait-state instance: request presented continuously.
        ops0[0] = '{1'b1, 32'h0, 3'b010, 32'h11223344, 32'h0, 1'b0};
        ops0[1] = '{1'b1, 32'h4, 3'b010, 32'h8899AABB, 32'h0, 1'b0};
        ops0[2] = '{1'b0, 32'h0, 3'b010, 32'h0, 32'h11223344, 1'b0};
        ops0[3] = '{1'b0, 32'h6, 3'b001, 32'h0, 32'hFFFF8899, 1'b0};
        ops0[4] = '{1'b0, 32'h0, 3'b011, 32'h0, 32'h0, 1'b1};
        ops0[5] = '{1'b0, 32'h5, 3'b100, 32'h0, 32'h000000AA, 1'b0};
        begin
            int  k, r, first_c, last_c;
            bit  prev_issue;
            k = 0; r = 0; first_c = 0; last_c = 0; prev_issue = 0;
            resp_ready0 = 1;
            for (int c = 0; c < 40 && r < 6; c++) begin
                @(negedge clk);
                if (resp_valid0) begin
                    chk("w0_latency", {31'd0, prev_issue}, 32'd1);
                    chk("w0_rdata", resp_rdata0, ops0[r].rd);
                    chk("w0_err", {31'd0, resp_err0}, {31'd0, ops0[r].err});
                    if (r == 0) first_c = c;
                    last_c = c;
                    r++;
                end
                prev_issue = 0;
                if (k < 6) begin
                    req_valid0 = 1;
                    req_we0    = ops0[k].we;
                    req_addr0  = ops0[k].addr;
                    req_size0  = ops0[k].size;
                    req_wdata0 = ops0[k].wd;
                    if (req_ready0) begin
                        k++;
                        prev_issue = 1;
                    end
                end else begin
                    req_valid0 = 0;
                end
            end
            req_valid0 = 0;
            chk("w0_count", 32'(r), 32'd6);
            chk("w0_rate", 32'(last_c - first_c), 32'd10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 32-bit words of storage; it SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, sets the wait-state count per access; the legal range SHALL be 0..15.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  the reset SHALL be synchronous and active-low.
REQ-005 req_valid  input  1  the processor presents a request.
REQ-006 req_ready  output  1  the block accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 req_wdata  input  32  store data, taken from the low-order bytes.
REQ-011 resp_valid  output  1  a response is available.
REQ-012 resp_ready  input  1  the processor consumes the response.
REQ-013 resp_rdata  output  32  load result after extension; 0 for stores.
REQ-014 resp_err  output  1  the access faulted (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where the state is IDLE and req_valid=1; addr, size, we and wdata SHALL be captured on that edge.
REQ-017 After an accept the FSM SHALL go to WAIT with its counter loaded to WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
REQ-018 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-019 resp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Store commit and load sampling SHALL occur on the edge that enters RESP.
REQ-021 resp_valid, resp_rdata and resp_err SHALL stay stable in RESP until an edge where resp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-022 A new request SHALL NOT be accepted on the same edge a response is consumed.
REQ-023 The word index SHALL be addr[log2(DEPTH)+1:2]; byte lane = addr[1:0]; half lane = addr[1].
REQ-024 Stores SHALL byte-enable: SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes; all other lanes SHALL be unchanged.
REQ-025 Loads SHALL extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-026 An unsupported req_size (011, 110, 111) SHALL perform no write, return rdata=0 and set resp_err=1 regardless of configuration.
REQ-027 A store followed by a load to the same word SHALL return the stored data, with no forwarding hazard because accesses are serialized.

Reset
REQ-028 On an edge with reset=0: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after reset is released.
REQ-029 Reset during WAIT or RESP SHALL abort the access; an uncommitted store SHALL be dropped.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro DATA_MEM_RESP_ERR_EN, when defined:
- A misaligned access (half with addr[0]=1, word with addr[1:0]≠0) SHALL set resp_err=1.
- An out-of-range address (addr ≥ 4·DEPTH) SHALL set resp_err=1.
- A faulting access SHALL perform no write and return rdata=0; latency SHALL be unchanged.
REQ-032 When DATA_MEM_RESP_ERR_EN is undefined:
- Address bits below the access size SHALL be ignored (the access is aligned down).
- Upper address bits SHALL wrap modulo 4·DEPTH.
- resp_err SHALL be set only by REQ-026.

Verification
REQ-033 WAIT_CYCLES=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid 2 cycles after each accept.
REQ-034 After REQ-033, SB addr 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF; LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
REQ-035 resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stable for 5 cycles; req_ready stays 0; IDLE is reached the cycle after resp_ready=1.
REQ-036 With ERR_EN, LW 0x12 -> err 1, rdata 0; SH 0x13 -> err 1, memory unchanged; without ERR_EN, LW 0x12 -> word at 0x10.
REQ-037 Accept a SW to 0x20, then assert reset=0 in WAIT -> after reset, LW 0x20 returns the old contents; req_ready=1 and resp_valid=0 after reset.
REQ-038 WAIT_CYCLES=0 back-to-back loads with resp_ready=1 -> one response every 2 cycles; size 011 -> err 1.
